// File: rtl/vga_timing_ctrl_if.sv
// rtl/vga_timing_ctrl_if.sv - timing/pattern-select bundle between sequencer and pattern generator
interface vga_timing_ctrl_if;
    logic       hold;
    logic [9:0] column;
    logic [9:0] row;
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic       frame_start;
    logic [1:0] pattern_sel;

    modport master (
        input  hold,
        output column, row, hsync, vsync, visible, frame_start, pattern_sel
    );

    modport slave (
        output hold,
        input  column, row, hsync, vsync, visible, frame_start, pattern_sel
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA h/v counters, registered sync/visible decodes, pattern scheduler
module vga_timing_ctrl #(
    parameter int H_VISIBLE          = 640,
    parameter int H_FRONT            = 16,
    parameter int H_SYNC             = 96,
    parameter int H_BACK             = 48,
    parameter int V_VISIBLE          = 480,
    parameter int V_FRONT            = 10,
    parameter int V_SYNC             = 2,
    parameter int V_BACK             = 33,
    parameter int NUM_PATTERNS       = 4,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic               clk,
    input  logic               reset_n,
    vga_timing_ctrl_if.master  vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [6:0] FC_LAST  = 7'(FRAMES_PER_PATTERN - 1);
    localparam logic [1:0] PAT_LAST = 2'(NUM_PATTERNS - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [6:0] frame_cnt;
    logic [1:0] pat;
    logic       h_wrap;
    logic       frame_wrap;

    assign h_wrap     = (h_cnt == H_LAST);
    assign frame_wrap = h_wrap && (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // pat moves at the wrap edge, so its registered copy lands with the (0,0) outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            pat       <= '0;
        end else if (frame_wrap && !vga.hold) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt <= '0;
                pat       <= (pat == PAT_LAST) ? 2'd0 : pat + 2'd1;
            end else begin
                frame_cnt <= frame_cnt + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga.column      <= '0;
            vga.row         <= '0;
            vga.hsync       <= 1'b1;
            vga.vsync       <= 1'b1;
            vga.visible     <= 1'b0;
            vga.frame_start <= 1'b0;
            vga.pattern_sel <= '0;
        end else begin
            vga.column      <= h_cnt;
            vga.row         <= v_cnt;
            vga.hsync       <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
            vga.vsync       <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
            vga.visible     <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
            vga.frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
            vga.pattern_sel <= pat;
        end
    end
endmodule
